// File: rtl/bcd_a_bin_seq_if.sv
// Start/busy/done bundle for the BCD-to-binary converter.
// The master drives the request; the slave returns the result.
interface bcd_a_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, bcd,
        input  bin, busy, done, err
    );

    modport slave (
        input  start, bcd,
        output bin, busy, done, err
    );
endinterface

// File: rtl/bcd_a_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each CONV cycle does one right shift, then a -3 fix on every digit >= 8.
module bcd_a_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic            clk,
    input  logic            rst,
    bcd_a_bin_seq_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int WW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, FAULT} state_t;

    state_t            state, state_n;
    logic [WW-1:0]     work, work_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BIN_W-1:0]  bin_q, bin_n;
    logic              err_q, err_n;
    logic              done_q, done_n;
    logic              bad;
    logic [WW-1:0]     shifted;
    logic [WW-1:0]     fixed;

    always_comb begin
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.bcd[4*d +: 4] > 4'd9) bad = 1'b1;
        end
    end

    // Correction applies to the BCD field only; the binary field is untouched.
    always_comb begin
        shifted = work >> 1;
        fixed   = shifted;
        for (int d = 0; d < DIGITS; d++) begin
            if (shifted[BIN_W+4*d +: 4] >= 4'd8) begin
                fixed[BIN_W+4*d +: 4] = shifted[BIN_W+4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        bin_n   = bin_q;
        err_n   = err_q;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bad) begin
                        state_n = FAULT;
                    end else begin
                        work_n  = {bus.bcd, {BIN_W{1'b0}}};
                        cnt_n   = '0;
                        state_n = CONV;
                    end
                end
            end
            CONV: begin
                work_n = fixed;
                cnt_n  = cnt + 1'b1;
                if (cnt == CW'(BIN_W - 1)) begin
                    bin_n   = shifted[BIN_W-1:0];
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            FAULT: begin
                bin_n   = '0;
                err_n   = 1'b1;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            work   <= work_n;
            cnt    <= cnt_n;
            bin_q  <= bin_n;
            err_q  <= err_n;
            done_q <= done_n;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_a_bin_seq.sv
// Bench for bcd_a_bin_seq: directed conversions with literal expectations
// plus a cycle-level transaction model checked on every falling edge.
module tb_bcd_a_bin_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_a_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_a_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [4*DIGITS-1:0] b);
        int v = 0;
        for (int d = DIGITS - 1; d >= 0; d--) v = v * 10 + int'(b[4*d +: 4]);
        return v;
    endfunction

    function automatic bit ok(input logic [4*DIGITS-1:0] b);
        for (int d = 0; d < DIGITS; d++) if (b[4*d +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Transaction model: applies the inputs seen at the previous falling
    // edge as the rising edge in between, then compares all outputs.
    bit   armed = 0;
    bit   pend  = 0;
    bit   p_rst, p_start;
    logic [4*DIGITS-1:0] p_bcd;
    bit   mbusy = 0, mdone = 0, merr = 0, perr = 0, prev_done = 0;
    int   mleft = 0, mbin = 0, pbin = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                if (p_rst) begin
                    mbusy = 0; mdone = 0; mbin = 0; merr = 0;
                    armed = 1;
                end else begin
                    mdone = 0;
                    if (mbusy) begin
                        mleft--;
                        if (mleft == 0) begin
                            mbusy = 0; mdone = 1;
                            mbin = pbin; merr = perr;
                        end
                    end else if (p_start) begin
                        mbusy = 1;
                        if (ok(p_bcd)) begin
                            mleft = BIN_W; pbin = dec(p_bcd); perr = 0;
                        end else begin
                            mleft = 1; pbin = 0; perr = 1;
                        end
                    end
                end
            end
            if (armed) begin
                chk("m_done", {31'b0, bus.done}, {31'b0, mdone});
                chk("m_busy", {31'b0, bus.busy}, {31'b0, mbusy});
                chk("m_bin", {18'b0, bus.bin}, mbin);
                chk("m_err", {31'b0, bus.err}, {31'b0, merr});
                chk("done_twice", {31'b0, bus.done & prev_done}, 0);
                prev_done = bus.done;
            end
            p_rst = rst; p_start = bus.start; p_bcd = bus.bcd; pend = 1;
        end
    end

    task automatic do_conv(input logic [15:0] b, input int exp_bin,
                           input int exp_err, input int exp_lat,
                           input string name);
        int n = 0;
        bus.start = 1'b1;
        bus.bcd   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_bin"}, {18'b0, bus.bin}, exp_bin);
        chk({name, "_err"}, {31'b0, bus.err}, exp_err);
        chk({name, "_busy"}, {31'b0, bus.busy}, 0);
    endtask

    initial begin
        int n;
        logic [15:0] b;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bcd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin", {18'b0, bus.bin}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_err", {31'b0, bus.err}, 0);
        rst = 1'b0;

        do_conv(16'h0000, 14'h0000, 0, 14, "zero");

        do_conv(16'h0010, 14'h000A, 0, 14, "b2b_10");
        do_conv(16'h1234, 14'h04D2, 0, 14, "b2b_1234");
        do_conv(16'h9999, 14'h270F, 0, 14, "b2b_9999");

        do_conv(16'h1A00, 0, 1, 1, "fault");
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold", {31'b0, bus.err}, 1);
        do_conv(16'h0015, 14'h000F, 0, 14, "after_fault");
        do_conv(16'h000F, 0, 1, 1, "fault_d0");
        do_conv(16'hB000, 0, 1, 1, "fault_d3");

        // Second start during a conversion must be ignored.
        bus.start = 1'b1;
        bus.bcd = 16'h0042;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        repeat (4) begin @(posedge clk); #1; n++; end
        bus.start = 1'b1;
        bus.bcd = 16'h0099;
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
        chk("ign_lat", n, 14);
        chk("ign_bin", {18'b0, bus.bin}, 14'h002A);
        chk("ign_err", {31'b0, bus.err}, 0);
        repeat (20) @(posedge clk);
        #1;

        // Reset in the middle of a conversion.
        bus.start = 1'b1;
        bus.bcd = 16'h0500;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 0);
        chk("abort_done", {31'b0, bus.done}, 0);
        chk("abort_bin", {18'b0, bus.bin}, 0);
        chk("abort_err", {31'b0, bus.err}, 0);
        repeat (20) @(posedge clk);
        #1;
        do_conv(16'h0500, 14'h01F4, 0, 14, "after_abort");

        for (int i = 0; i < 10000; i += 7) begin
            b = {4'(i / 1000), 4'((i / 100) % 10), 4'((i / 10) % 10), 4'(i % 10)};
            do_conv(b, i, 0, 14, "sweep");
        end
        do_conv(16'h9998, 9998, 0, 14, "sweep_top");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
